// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and types for the audio stream endpoint.
//   SAMPLE_W        - controller stream sample width
//   DEF_TIMEOUT_CYC - default cycles to wait for a DSP result
//   dsp_state_e     - dispatch FSM states
package audio_pkg;

    localparam int unsigned SAMPLE_W        = 24;
    localparam int unsigned DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        PUSH  = 2'd3
    } dsp_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-bit pointers for full/empty detection.
//   clk, reset_n   - clock, asynchronous active-low reset (empties FIFO, clears storage)
//   wr_en, din     - write strobe and data (ignored when full)
//   rd_en          - pop strobe (ignored when empty)
//   full, empty    - status flags derived from the registered pointers
//   dout           - current head entry
module sync_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr;
    logic             w_rd;

    // Same index with differing wrap bit means the writer has lapped the reader.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr  = wr_en && !full;
    assign w_rd  = rd_en && !empty;
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[AW-1:0]] <= din;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/audio_stream_endpoint.sv
// audio_stream_endpoint: fabric endpoint for one audio controller channel.
// RX samples are buffered, sent one at a time to the reverb core and the
// result (or the dry sample on timeout) is buffered for TX. bypass routes
// samples straight from RX to TX.
//   clk, reset_n                 - clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready    - Avalon-ST sink (ADC samples)
//   tx_data/tx_valid/tx_ready    - Avalon-ST source (DAC samples)
//   dsp_sample/dsp_sample_valid  - sample issued to the reverb core
//   dsp_result/dsp_result_valid  - processed sample from the reverb core
//   bypass                       - dry RX->TX routing, sampled in IDLE only
//   stat_clr                     - clears overrun_cnt and timeout_flag
//   overrun_cnt                  - saturating count of refused rx_valid cycles
//   timeout_flag                 - sticky DSP timeout indicator
module audio_stream_endpoint
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W      = SAMPLE_W,
    parameter int unsigned RX_DEPTH    = 4,
    parameter int unsigned TX_DEPTH    = 4,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] dsp_sample,
    output logic              dsp_sample_valid,
    input  logic [DATA_W-1:0] dsp_result,
    input  logic              dsp_result_valid,
    input  logic              bypass,
    input  logic              stat_clr,
    output logic [15:0]       overrun_cnt,
    output logic              timeout_flag
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    dsp_state_e        r_state;
    logic [DATA_W-1:0] r_dsp_sample;
    logic [DATA_W-1:0] r_dry;
    logic [DATA_W-1:0] r_res;
    logic              r_dsp_valid;
    logic [TW-1:0]     r_to_cnt;
    logic              r_timeout;
    logic [15:0]       r_ovr_cnt;
    logic              r_active;

    logic              w_rx_full;
    logic              w_rx_empty;
    logic [DATA_W-1:0] w_rx_head;
    logic              w_rx_wr;
    logic              w_rx_pop;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_tx_push;
    logic [DATA_W-1:0] w_tx_din;
    logic              w_tx_pop;

    // r_active keeps rx_ready low while reset is held even though the FIFO
    // flags read "not full" then.
    assign rx_ready         = r_active && !w_rx_full;
    assign w_rx_wr          = rx_valid && rx_ready;
    assign tx_valid         = !w_tx_empty;
    assign w_tx_pop         = tx_valid && tx_ready;
    assign dsp_sample       = r_dsp_sample;
    assign dsp_sample_valid = r_dsp_valid;
    assign overrun_cnt      = r_ovr_cnt;
    assign timeout_flag     = r_timeout;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_rx_wr),
        .din     (rx_data),
        .rd_en   (w_rx_pop),
        .full    (w_rx_full),
        .empty   (w_rx_empty),
        .dout    (w_rx_head)
    );

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_tx_push),
        .din     (w_tx_din),
        .rd_en   (w_tx_pop),
        .full    (w_tx_full),
        .empty   (w_tx_empty),
        .dout    (tx_data)
    );

    // FIFO strobes follow the current state; the bypass move is a same-cycle
    // pop/push so the RX head goes straight into TX.
    always_comb begin
        w_rx_pop  = 1'b0;
        w_tx_push = 1'b0;
        w_tx_din  = r_res;
        case (r_state)
            IDLE: begin
                if (!w_rx_empty) begin
                    if (!bypass) begin
                        w_rx_pop = 1'b1;
                    end else if (!w_tx_full) begin
                        w_rx_pop  = 1'b1;
                        w_tx_push = 1'b1;
                        w_tx_din  = w_rx_head;
                    end
                end
            end
            PUSH: begin
                w_tx_push = !w_tx_full;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_dsp_sample <= '0;
            r_dry        <= '0;
            r_res        <= '0;
            r_dsp_valid  <= 1'b0;
            r_to_cnt     <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_dsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_empty && !bypass) begin
                        r_dsp_sample <= w_rx_head;
                        r_dry        <= w_rx_head;
                        r_dsp_valid  <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_to_cnt <= '0;
                    r_state  <= WAIT;
                end
                WAIT: begin
                    // A result in the timeout cycle still wins over the dry sample.
                    if (dsp_result_valid) begin
                        r_res   <= dsp_result;
                        r_state <= PUSH;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_res     <= r_dry;
                        r_timeout <= 1'b1;
                        r_state   <= PUSH;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                PUSH: begin
                    if (!w_tx_full) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (stat_clr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active  <= 1'b0;
            r_ovr_cnt <= '0;
        end else begin
            r_active <= 1'b1;
            if (stat_clr) begin
                r_ovr_cnt <= '0;
            end else if (rx_valid && !rx_ready && (r_ovr_cnt != 16'hFFFF)) begin
                r_ovr_cnt <= r_ovr_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_stream_endpoint.sv
// Directed bench for audio_stream_endpoint (TIMEOUT_CYC=16). Inputs are driven
// and outputs observed on the falling edge; "cycle N" counts rising edges after
// the cycle in which a sample is offered.
module tb_audio_stream_endpoint;

    localparam int unsigned DW = 24;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] dsp_sample;
    logic          dsp_sample_valid;
    logic [DW-1:0] dsp_result = '0;
    logic          dsp_result_valid = 1'b0;
    logic          bypass = 1'b0;
    logic          stat_clr = 1'b0;
    logic [15:0]   overrun_cnt;
    logic          timeout_flag;

    int checks = 0;
    int failures = 0;

    audio_stream_endpoint #(
        .DATA_W      (DW),
        .RX_DEPTH    (4),
        .TX_DEPTH    (4),
        .TIMEOUT_CYC (TO)
    ) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .dsp_sample       (dsp_sample),
        .dsp_sample_valid (dsp_sample_valid),
        .dsp_result       (dsp_result),
        .dsp_result_valid (dsp_result_valid),
        .bypass           (bypass),
        .stat_clr         (stat_clr),
        .overrun_cnt      (overrun_cnt),
        .timeout_flag     (timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check_eq({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check_eq({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check_eq({tag, "_dsp_sample"}, 32'(dsp_sample), 32'd0);
        check_eq({tag, "_dsp_valid"}, 32'(dsp_sample_valid), 32'd0);
        check_eq({tag, "_overrun"}, 32'(overrun_cnt), 32'd0);
        check_eq({tag, "_timeout"}, 32'(timeout_flag), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int n;
        int first;
        int pulses;
        int acc;

        // Reset
        @(negedge clk);
        check_reset_state("rst");
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_rx_ready_after", 32'(rx_ready), 32'd1);

        // Test 1: DSP round trip
        rx_data = 24'h123456; rx_valid = 1'b1;           // cycle 0
        @(negedge clk); rx_valid = 1'b0;                  // cycle 1
        check_eq("t1_dsv_c1", 32'(dsp_sample_valid), 32'd0);
        @(negedge clk);                                   // cycle 2
        check_eq("t1_dsv_c2", 32'(dsp_sample_valid), 32'd1);
        check_eq("t1_dsp_sample", 32'(dsp_sample), 32'h123456);
        @(negedge clk);                                   // cycle 3
        check_eq("t1_dsv_c3", 32'(dsp_sample_valid), 32'd0);
        repeat (4) @(negedge clk);                        // cycle 7
        dsp_result = 24'h00ABCD; dsp_result_valid = 1'b1;
        @(negedge clk); dsp_result_valid = 1'b0;          // cycle 8 (PUSH)
        check_eq("t1_tx_valid_c8", 32'(tx_valid), 32'd0);
        @(negedge clk);                                   // cycle 9
        check_eq("t1_tx_valid_c9", 32'(tx_valid), 32'd1);
        check_eq("t1_tx_data", 32'(tx_data), 32'h00ABCD);
        tx_ready = 1'b1;
        @(negedge clk); tx_ready = 1'b0;
        check_eq("t1_tx_drained", 32'(tx_valid), 32'd0);

        // Test 2: bypass streaming
        bypass = 1'b1; tx_ready = 1'b1;
        n = 0; first = -1; pulses = 0;
        for (int i = 0; i < 16; i++) begin
            if (tx_valid) begin
                if (first < 0) first = i;
                check_eq($sformatf("t2_tx%0d", n), 32'(tx_data), 32'(n + 1));
                n++;
            end
            if (dsp_sample_valid) pulses++;
            if (i < 8) begin
                rx_valid = 1'b1; rx_data = DW'(i + 1);
            end else begin
                rx_valid = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("t2_first_cycle", 32'(first), 32'd2);
        check_eq("t2_count", 32'(n), 32'd8);
        check_eq("t2_dsp_pulses", 32'(pulses), 32'd0);

        // Test 3: backpressure and overrun
        tx_ready = 1'b0; acc = 0;
        for (int i = 0; i < 12; i++) begin
            rx_valid = 1'b1;
            rx_data  = DW'(32'h100 + acc);
            if (rx_ready) acc++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check_eq("t3_accepted", 32'(acc), 32'd8);
        check_eq("t3_rx_ready", 32'(rx_ready), 32'd0);
        check_eq("t3_overrun", 32'(overrun_cnt), 32'd4);
        tx_ready = 1'b1; n = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx_valid) begin
                check_eq($sformatf("t3_drain%0d", n), 32'(tx_data), 32'(32'h100 + n));
                n++;
            end
            @(negedge clk);
        end
        check_eq("t3_drain_count", 32'(n), 32'd8);
        tx_ready = 1'b0; bypass = 1'b0;

        // Test 4: DSP timeout fallback, then stat_clr
        rx_data = 24'h0DEAD1; rx_valid = 1'b1;           // cycle 0
        @(negedge clk); rx_valid = 1'b0; c = 1;
        while (!tx_valid && c < 60) begin
            @(negedge clk); c++;
        end
        check_eq("t4_latency", 32'(c), 32'd20);
        check_eq("t4_tx_data", 32'(tx_data), 32'h0DEAD1);
        check_eq("t4_timeout_flag", 32'(timeout_flag), 32'd1);
        check_eq("t4_overrun_kept", 32'(overrun_cnt), 32'd4);
        tx_ready = 1'b1;
        @(negedge clk); tx_ready = 1'b0;
        stat_clr = 1'b1;
        @(negedge clk); stat_clr = 1'b0;
        check_eq("t4_clr_timeout", 32'(timeout_flag), 32'd0);
        check_eq("t4_clr_overrun", 32'(overrun_cnt), 32'd0);

        // Test 5a: stray result in IDLE
        dsp_result = 24'h777777; dsp_result_valid = 1'b1;
        @(negedge clk); dsp_result_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t5_idle_result_ignored", 32'(tx_valid), 32'd0);

        // Test 5b: result in the timeout cycle wins
        rx_data = 24'h0D0D0D; rx_valid = 1'b1;           // cycle 0
        @(negedge clk); rx_valid = 1'b0;                  // cycle 1
        @(negedge clk);                                   // cycle 2
        check_eq("t5_dsv_c2", 32'(dsp_sample_valid), 32'd1);
        repeat (16) @(negedge clk);                       // cycle 18
        dsp_result = 24'h0E0E0E; dsp_result_valid = 1'b1;
        @(negedge clk); dsp_result_valid = 1'b0;          // cycle 19
        @(negedge clk);                                   // cycle 20
        check_eq("t5_tx_valid", 32'(tx_valid), 32'd1);
        check_eq("t5_tx_data", 32'(tx_data), 32'h0E0E0E);
        check_eq("t5_no_timeout", 32'(timeout_flag), 32'd0);
        tx_ready = 1'b1;
        @(negedge clk); tx_ready = 1'b0;

        // Test 6: reset during WAIT with 3 samples buffered
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = DW'(32'hA1 + i);
            @(negedge clk);
        end
        rx_valid = 1'b0;                                  // cycle 4, FSM in WAIT
        check_eq("t6_dsp_sample_pre", 32'(dsp_sample), 32'hA1);
        #2 reset_n = 1'b0;
        #1 check_reset_state("t6_rst");
        @(negedge clk); reset_n = 1'b1;
        n = 0; pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_valid) n++;
            if (dsp_sample_valid) pulses++;
        end
        check_eq("t6_no_stale_tx", 32'(n), 32'd0);
        check_eq("t6_no_stale_dsp", 32'(pulses), 32'd0);
        check_eq("t6_rx_ready", 32'(rx_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
